// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg
// Shared types and constants for the FIFO read-side drain block.
//   rd_state_e   : controller states (IDLE / STREAM / FLUSH)
//   DEF_DATASIZE : default FIFO word width
//   DEF_BURST    : default beats per m_last burst
//   CNT_W        : width of the optional delivered-word counter
//   BEAT_W       : width of the in-burst beat counter (BURST up to 255)
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } rd_state_e;

  localparam int DEF_DATASIZE = 8;
  localparam int DEF_BURST    = 4;
  localparam int CNT_W        = 16;
  localparam int BEAT_W       = 8;

endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid
// Two-entry in-order output buffer sitting between the FIFO pop and the
// valid/ready stream. The head entry drives dout directly.
// Ports:
//   rclk, rrst : read clock, async active-high reset
//   clear      : drop all entries (wins over push/pop)
//   push, din  : write a word (ignored when full)
//   pop        : remove the head entry (ignored when empty)
//   dout       : head word, valid : buffer non-empty, occ : 0..2 entries
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int DATASIZE = DEF_DATASIZE
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                clear,
  input  logic                push,
  input  logic [DATASIZE-1:0] din,
  input  logic                pop,
  output logic [DATASIZE-1:0] dout,
  output logic                valid,
  output logic [1:0]          occ
);

  logic [DATASIZE-1:0] head_q, head_d;
  logic [DATASIZE-1:0] tail_q, tail_d;
  logic [1:0]          occ_q, occ_d;
  logic                do_push, do_pop;

  assign do_push = push && (occ_q != 2'd2);
  assign do_pop  = pop && (occ_q != 2'd0);

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (clear) begin
      occ_d = 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (occ_q == 2'd0) head_d = din;
          else               tail_d = din;
          occ_d = occ_q + 2'd1;
        end
        2'b01: begin
          if (occ_q == 2'd2) head_d = tail_q;
          occ_d = occ_q - 2'd1;
        end
        2'b11: begin
          // occupancy 1: the incoming word replaces the departing head
          head_d = din;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign dout  = head_q;
  assign valid = (occ_q != 2'd0);
  assign occ   = occ_q;

endmodule

// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain
// Read-clock-domain consumer for the async FIFO. Pops words while the FIFO
// is non-empty and the output buffer has room, presents them as a
// valid/ready stream framed into bursts by m_last, and offers a flush that
// discards buffered and queued words, ending with a flush_done pulse.
// Optional feature macro: FIFO_RD_CNT_EN adds the 16-bit word_cnt port.
// Ports:
//   rclk, rrst            : read clock, async active-high reset
//   en, flush             : stream enable (level), flush request (pulse)
//   rempty, rdata, rinc   : fall-through FIFO read face
//   m_valid/m_ready/m_data/m_last : output stream
//   flush_done            : one-cycle flush completion pulse
//   word_cnt              : accepted-beat count (FIFO_RD_CNT_EN only)
//
// state  | meaning
// IDLE   | no pops; buffered words still drain
// STREAM | pop whenever FIFO non-empty and buffer has room
// FLUSH  | buffer empty, pop and discard until FIFO empty
module fifo_rd_drain
  import fifo_rd_pkg::*;
#(
  parameter int DATASIZE = DEF_DATASIZE,
  parameter int BURST    = DEF_BURST
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                en,
  input  logic                flush,
  input  logic                rempty,
  input  logic [DATASIZE-1:0] rdata,
  output logic                rinc,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DATASIZE-1:0] m_data,
  output logic                m_last,
  output logic                flush_done
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [CNT_W-1:0]    word_cnt
`endif
);

  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST - 1);

  rd_state_e         state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              flush_done_q, flush_done_d;
  logic              push, clear, accept;
  logic [1:0]        occ;

  fifo_rd_skid #(.DATASIZE(DATASIZE)) u_skid (
    .rclk  (rclk),
    .rrst  (rrst),
    .clear (clear),
    .push  (push),
    .din   (rdata),
    .pop   (accept),
    .dout  (m_data),
    .valid (m_valid),
    .occ   (occ)
  );

  assign accept = m_valid && m_ready;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      flush_done_q <= flush_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = FLUSH;
    end else begin
      case (state_q)
        IDLE:    state_d = en ? STREAM : IDLE;
        STREAM:  state_d = en ? STREAM : IDLE;
        FLUSH:   state_d = rempty ? IDLE : FLUSH;
        default: state_d = IDLE;
      endcase
    end
  end

  // rinc depends only on state, rempty and occupancy; never on m_ready.
  always_comb begin
    rinc         = 1'b0;
    push         = 1'b0;
    clear        = flush;
    flush_done_d = 1'b0;
    case (state_q)
      STREAM: begin
        rinc = !rempty && (occ != 2'd2);
        // a word popped in the flush request cycle is discarded
        push = rinc && !flush;
      end
      FLUSH: begin
        rinc         = !rempty;
        flush_done_d = rempty && !flush;
      end
      default: ;
    endcase
  end

  always_comb begin
    beat_d = beat_q;
    if (clear || (state_q == FLUSH)) beat_d = '0;
    else if (accept) beat_d = (beat_q == BEAT_MAX) ? '0 : beat_q + BEAT_W'(1);
  end

  assign m_last     = m_valid && (beat_q == BEAT_MAX);
  assign flush_done = flush_done_q;

`ifdef FIFO_RD_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // not cleared by flush; free-running wrap at 0xFFFF
  assign cnt_d = accept ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign word_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
module tb_fifo_rd_drain;

  localparam int DW    = 8;
  localparam int BURST = 4;
  localparam int M_OFF = 0;
  localparam int M_ON  = 1;
  localparam int M_FL  = 2;

  logic          rclk = 1'b0;
  logic          rrst = 1'b1;
  logic          en = 1'b0;
  logic          flush = 1'b0;
  logic          rempty = 1'b1;
  logic [DW-1:0] rdata = '0;
  logic          m_ready = 1'b0;
  logic          rinc, m_valid, m_last, flush_done;
  logic [DW-1:0] m_data;
`ifdef FIFO_RD_CNT_EN
  logic [15:0]   word_cnt;
`endif

  fifo_rd_drain #(.DATASIZE(DW), .BURST(BURST)) dut (
    .rclk       (rclk),
    .rrst       (rrst),
    .en         (en),
    .flush      (flush),
    .rempty     (rempty),
    .rdata      (rdata),
    .rinc       (rinc),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .flush_done (flush_done)
`ifdef FIFO_RD_CNT_EN
    ,
    .word_cnt   (word_cnt)
`endif
  );

  always #5 rclk = ~rclk;

  int checks = 0;
  int errors = 0;

  // reference model: source FIFO contents, words owed downstream, burst position
  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];
  int            mode = M_OFF;
  int            beat = 0;
  logic [15:0]   cnt = '0;
  bit            done_exp = 1'b0;
  bit            gap = 1'b0;

  // observed DUT activity
  int            d_pop = 0, d_hs = 0, d_done = 0, cyc = 0;
  int            hs_log[$];
  logic [DW-1:0] last_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive_fifo();
    rempty = gap || (src_q.size() == 0);
    rdata  = (src_q.size() != 0) ? src_q[0] : '0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    mode     = M_OFF;
    beat     = 0;
    cnt      = '0;
    done_exp = 1'b0;
  endtask

  task automatic cycle();
    bit            exp_rinc, exp_valid, hs;
    logic [DW-1:0] w;
    drive_fifo();
    @(negedge rclk);
    exp_valid = (exp_q.size() != 0);
    if (mode == M_ON)      exp_rinc = !rempty && (exp_q.size() < 2);
    else if (mode == M_FL) exp_rinc = !rempty;
    else                   exp_rinc = 1'b0;
    chk("rinc", 32'(rinc), 32'(exp_rinc));
    chk("rinc_while_empty", 32'(rinc && rempty), 32'd0);
    chk("m_valid", 32'(m_valid), 32'(exp_valid));
    if (exp_valid) chk("m_data", 32'(m_data), 32'(exp_q[0]));
    chk("m_last", 32'(m_last), 32'(exp_valid && (beat == BURST - 1)));
    chk("flush_done", 32'(flush_done), 32'(done_exp));
`ifdef FIFO_RD_CNT_EN
    chk("word_cnt", 32'(word_cnt), 32'(cnt));
`endif
    if (rinc) d_pop++;
    if (flush_done) d_done++;
    if (m_valid && m_ready) begin
      d_hs++;
      hs_log.push_back(cyc);
      if (m_last) last_data = m_data;
    end
    // model the effect of the coming edge
    hs = exp_valid && m_ready;
    if (hs) begin
      void'(exp_q.pop_front());
      beat = (beat == BURST - 1) ? 0 : beat + 1;
      cnt  = cnt + 16'd1;
    end
    if (exp_rinc) begin
      w = src_q.pop_front();
      if (mode == M_ON && !flush) exp_q.push_back(w);
    end
    if (flush) begin
      exp_q.delete();
      beat     = 0;
      mode     = M_FL;
      done_exp = 1'b0;
    end else if (mode == M_FL) begin
      done_exp = rempty;
      if (rempty) mode = M_OFF;
    end else begin
      done_exp = 1'b0;
      mode     = en ? M_ON : M_OFF;
    end
    @(posedge rclk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic reset_checks();
    chk("rst_rinc", 32'(rinc), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_flush_done", 32'(flush_done), 32'd0);
`ifdef FIFO_RD_CNT_EN
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
`endif
  endtask

  task automatic do_reset();
    drive_fifo();
    #2;
    rrst = 1'b1;
    #1;
    reset_checks();
    @(posedge rclk);
    #1;
    rrst = 1'b0;
    model_reset();
  endtask

  int p0, h0, dn0;

  initial begin
    // power-on reset
    #1;
    reset_checks();
    @(posedge rclk);
    #1;
    rrst = 1'b0;
    model_reset();

    // basic stream
    en = 1'b1; m_ready = 1'b1;
    src_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    p0 = d_pop; h0 = d_hs; hs_log.delete(); last_data = '0;
    run(8);
    chk("basic_pops", 32'(d_pop - p0), 32'd4);
    chk("basic_beats", 32'(d_hs - h0), 32'd4);
    if (hs_log.size() == 4) chk("basic_back_to_back", 32'(hs_log[3] - hs_log[0]), 32'd3);
    else chk("basic_beat_log", 32'(hs_log.size()), 32'd4);
    chk("basic_last_word", 32'(last_data), 32'hD4);

    // backpressure
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) src_q.push_back(8'(8'h10 + i));
    p0 = d_pop;
    run(10);
    chk("bp_pops", 32'(d_pop - p0), 32'd2);
    chk("bp_head_held", 32'(m_data), 32'h10);
    m_ready = 1'b1;
    h0 = d_hs;
    run(12);
    chk("bp_delivered", 32'(d_hs - h0), 32'd6);

    // empty gaps every other cycle
    for (int i = 0; i < 8; i++) src_q.push_back(8'(8'h30 + 3 * i));
    h0 = d_hs;
    for (int i = 0; i < 30; i++) begin
      gap = i[0];
      cycle();
    end
    gap = 1'b0;
    chk("gap_delivered", 32'(d_hs - h0), 32'd8);

    // flush with 2 buffered, 3 still in the FIFO
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) src_q.push_back(8'(8'h60 + i));
    p0 = d_pop;
    run(4);
    chk("fl_prefill_pops", 32'(d_pop - p0), 32'd2);
    en = 1'b0; flush = 1'b1;
    cycle();
    flush = 1'b0;
    p0 = d_pop; dn0 = d_done;
    run(8);
    chk("fl_discard_pops", 32'(d_pop - p0), 32'd3);
    chk("fl_done_pulses", 32'(d_done - dn0), 32'd1);
    src_q.push_back(8'hF0);
    p0 = d_pop;
    run(3);
    chk("fl_idle_no_pop", 32'(d_pop - p0), 32'd0);
    en = 1'b1; m_ready = 1'b1;
    src_q.push_back(8'hF1); src_q.push_back(8'hF2); src_q.push_back(8'hF3);
    h0 = d_hs; last_data = '0;
    run(10);
    chk("fl_post_beats", 32'(d_hs - h0), 32'd4);
    chk("fl_beat_restart", 32'(last_data), 32'hF3);

    // disable mid-burst, resume from saved burst position
    src_q.push_back(8'h50);
    run(4);
    m_ready = 1'b0;
    src_q.push_back(8'h51);
    run(3);
    en = 1'b0;
    cycle();
    src_q.push_back(8'h52); src_q.push_back(8'h53); src_q.push_back(8'h54);
    m_ready = 1'b1;
    p0 = d_pop; h0 = d_hs;
    run(4);
    chk("dis_drained", 32'(d_hs - h0), 32'd1);
    chk("dis_no_pop", 32'(d_pop - p0), 32'd0);
    en = 1'b1; last_data = '0; h0 = d_hs;
    run(10);
    chk("dis_resume_beats", 32'(d_hs - h0), 32'd3);
    chk("dis_resume_last", 32'(last_data), 32'h53);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      en      = ($urandom_range(0, 7) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
      gap     = ($urandom_range(0, 3) == 0);
      flush   = ($urandom_range(0, 49) == 0);
      if (src_q.size() < 4 && $urandom_range(0, 1) == 1) src_q.push_back(8'($urandom));
      cycle();
    end
    flush = 1'b0; gap = 1'b0; en = 1'b1; m_ready = 1'b1;
    run(20);

    // reset with 2 words buffered
    m_ready = 1'b0;
    src_q.push_back(8'h71); src_q.push_back(8'h72); src_q.push_back(8'h73);
    run(4);
    chk("rst_pre_valid", 32'(m_valid), 32'd1);
    do_reset();
    en = 1'b0;
    run(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_drain.md
# fifo_rd_drain

Read-side consumer for the asynchronous FIFO. Lives entirely in the read clock domain, pops words whenever the FIFO is non-empty and buffer space exists, and presents them as a valid/ready stream with burst framing (`m_last`). Also provides a flush sequence that discards buffered and queued words and signals completion.

## Interface
- `DATASIZE`, 8, FIFO word width.
- `BURST`, 4, beats per burst for `m_last` framing; legal range 1..255.
- `rclk`  in  1  read clock.
- `rrst`  in  1  asynchronous, active-high reset.
- `en`  in  1  level; enables streaming.
- `flush`  in  1  single-cycle request to discard all data.
- `rempty`  in  1  FIFO empty flag, `rclk` domain.
- `rdata`  in  DATASIZE  FIFO head word, valid whenever `rempty`=0 (fall-through).
- `rinc`  out  1  FIFO pop; combinational.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  DATASIZE  output word.
- `m_last`  out  1  final beat of a burst; qualified by `m_valid`.
- `flush_done`  out  1  one-cycle pulse when the flush completes.
- `word_cnt`  out  16  delivered-beat count; present only with `FIFO_RD_CNT_EN`.

## Operation
- States: IDLE, STREAM, FLUSH.
- IDLE:
  - `rinc`=0.
  - Buffered words still drain to `m_*`.
  - `en`=1 moves to STREAM on the next edge.
- STREAM:
  - `rinc` = !rempty && (buffer occupancy < 2).
  - The word on `rdata` is written into the buffer on the same edge.
  - `en`=0 returns to IDLE; buffered words are still delivered.
- `flush`=1 in any state moves to FLUSH on the next edge. `flush` has priority over `en`.
- FLUSH:
  - Buffer is cleared on entry.
  - `m_valid`=0 throughout.
  - `rinc` = !rempty; popped words are discarded.
  - On the first cycle with `rempty`=1, pulse `flush_done` and go to IDLE.
  - The beat counter resets to 0.
- Output buffer: 2-entry FIFO, in-order.
  - Push and pop on the same edge are allowed when occupancy is 1.
  - No push is issued at occupancy 2.
- Beat counter:
  - Counts 0..BURST-1 on each `m_valid && m_ready`.
  - Wraps to 0 after BURST-1.
  - `m_last` = `m_valid` && (count == BURST-1).
- `m_data` and `m_valid` stay stable while `m_valid && !m_ready`.

## Timing
- Reset values:
  - State = IDLE.
  - `rinc`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `flush_done`=0.
  - Beat counter = 0; `word_cnt`=0.
- Latency: a FIFO head word popped at edge N appears on `m_data` with `m_valid`=1 after edge N.
- Throughput: one word per `rclk` with `m_ready` held high and the FIFO never empty.
- `rinc` is combinational from `rempty`, state and occupancy only. There is no path from `m_ready` to `rinc`.
- `flush_done` is asserted the cycle after the FLUSH state first samples `rempty`=1. The minimum flush length is 1 cycle (FIFO already empty).
- If reset is asserted mid-burst or mid-flush, all state clears immediately. No pop is issued while `rrst`=1.

## Configuration
- `FIFO_RD_CNT_EN`:
  - Defined: adds the `word_cnt` port, a 16-bit counter incremented on each accepted beat. It wraps 0xFFFF→0x0000, resets to 0 on reset, and is not cleared by flush.
  - Undefined: port and counter are absent; all other behaviour is identical.

## Structure
- Package `fifo_rd_pkg`: state enum `rd_state_e` {IDLE, STREAM, FLUSH}, default `DATASIZE`/`BURST` constants, `CNT_W`=16.
- Sub-module `fifo_rd_skid`: 2-entry buffer with push/pop/clear and occupancy. It is instantiated once.

## Test plan
- Basic stream:
  - Stimulus: reset, `en`=1, FIFO holds 0xA1,0xB2,0xC3,0xD4, `m_ready`=1.
  - Required: four beats in order on consecutive cycles, `m_last` on 0xD4 only, `rinc` high for exactly 4 cycles.
- Backpressure:
  - Stimulus: 6 words queued, `m_ready`=0 for 10 cycles.
  - Required: exactly 2 pops, then `rinc`=0; `m_data` holds the first word stable. After `m_ready`=1, all 6 are delivered in order with no loss or duplication.
- Empty gap:
  - Stimulus: `rempty` toggles 1/0 every cycle.
  - Required: `rinc` never asserted while `rempty`=1; every offered word delivered once.
- Flush:
  - Stimulus: 2 words buffered, 3 in the FIFO, pulse `flush`.
  - Required: `m_valid`=0 from the next cycle, 3 discard pops, one `flush_done` pulse, beat counter 0, state IDLE.
- Disable mid-burst:
  - Stimulus: `en`→0 with 1 word buffered.
  - Required: that word still delivered; no further `rinc`; re-enable resumes burst counting from the saved count.
- Reset mid-operation:
  - Stimulus: assert `rrst` with 2 words buffered.
  - Required: `m_valid`, `rinc` and `m_last` are 0 in the same cycle; `word_cnt`=0 (with `FIFO_RD_CNT_EN`).
